hex_pair_display_driver: RTL

- Downstream consumer of the 16-bit HEX5_HEX4 PIO out_port.
- Interprets the 16-bit word as one display byte plus control bits, and drives the two active-low seven-segment digits HEX5 (upper nibble) and HEX4 (lower nibble).
- Sequential features: input capture register, change-detect strobe, blink timer, and PWM brightness dimming.

---
 rtl/hex_pair_display_driver.sv | 125 ++++++++++++
 1 files changed

// File: rtl/hex_pair_display_driver.sv
// Two-digit active-low seven-segment driver fed by a 16-bit PIO word.
// The word carries a display byte plus blank, blink, PWM-brightness, suppress and lamp-test controls.
module hex_pair_display_driver #(
  parameter int CLK_HZ   = 50000000,
  parameter int BLINK_HZ = 2,
  parameter int PWM_BITS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] in_port,
  output logic [6:0]  hex4_n,
  output logic [6:0]  hex5_n,
  output logic        changed
);

  localparam int HALF  = CLK_HZ / (2 * BLINK_HZ);
  localparam int CNT_W = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [CNT_W-1:0]    HALF_M1 = CNT_W'(HALF - 1);
  localparam logic [PWM_BITS-1:0] BRI_MAX = {PWM_BITS{1'b1}};
  localparam logic [6:0]          SEG_OFF = 7'h7F;

  logic [15:0]         in_q;
  logic [15:0]         in_q_d;
  logic [CNT_W-1:0]    blink_cnt;
  logic                blink_phase;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [6:0]          hex4_nxt;
  logic [6:0]          hex5_nxt;

  logic [7:0]          value;
  logic [PWM_BITS-1:0] brightness;
  logic                blink_en;
  logic                blank;
  logic                lz_suppress;
  logic                lamp_test;
  logic                pwm_on;

  assign value       = in_q[7:0];
  assign brightness  = in_q[8 +: PWM_BITS];
  assign blink_en    = in_q[12];
  assign blank       = in_q[13];
  assign lz_suppress = in_q[14];
  assign lamp_test   = in_q[15];
  assign pwm_on      = (brightness == BRI_MAX) || (pwm_cnt < brightness);

  function automatic logic [6:0] seg_decode(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
    return seg;
  endfunction

  // Stage 0: capture the PIO word and its one-cycle-old copy
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_q    <= '0;
      in_q_d  <= '0;
      changed <= 1'b0;
    end else begin
      in_q    <= in_port;
      in_q_d  <= in_q;
      changed <= (in_q != in_q_d);
    end
  end

  // Free-running timers; blink is held in its on phase while disabled
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
      pwm_cnt     <= '0;
    end else begin
      pwm_cnt <= pwm_cnt + 1'b1;
      if (!blink_en) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b1;
      end else if (blink_cnt == HALF_M1) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    hex4_nxt = SEG_OFF;
    hex5_nxt = SEG_OFF;
    if (lamp_test) begin
      hex4_nxt = 7'h00;
      hex5_nxt = 7'h00;
    end else if (!blank && !(blink_en && !blink_phase) && pwm_on) begin
      hex4_nxt = seg_decode(value[3:0]);
      hex5_nxt = (lz_suppress && (value[7:4] == 4'h0)) ? SEG_OFF : seg_decode(value[7:4]);
    end
  end

  // Stage 1: registered segment outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hex4_n <= SEG_OFF;
      hex5_n <= SEG_OFF;
    end else begin
      hex4_n <= hex4_nxt;
      hex5_n <= hex5_nxt;
    end
  end

endmodule
